icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, log2 of sets.
REQ-002 SHALL have parameter WAYS, default 2, associativity (1, 2 or 4).
REQ-003 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, 1..16).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 resn  in  1  reset, asynchronous, active-low.
REQ-006 cached_instr_req  in  1  CPU fetch request, held until cached_instr_valid.
REQ-007 cached_instr_adr  in  32  CPU byte address; bits [1:0] ignored.
REQ-008 cached_instr_valid  out  1  one-cycle pulse, fetch data valid.
REQ-009 cached_instr_read  out  32  fetched word.
REQ-010 instr_req  out  1  downstream read request.
REQ-011 instr_adr  out  32  downstream word address.
REQ-012 instr_valid  in  1  downstream data valid pulse.
REQ-013 instr_read  in  32  downstream data.
REQ-014 flush  in  1  invalidate-all request (single-cycle pulse).
REQ-015 flush_busy  out  1  high while invalidation pending or running.

Function
REQ-016 Address split SHALL be: word offset [WO+1:2] (WO = log2 LINE_WORDS), index next INDEX_BITS bits, tag the remaining upper bits.
REQ-017 FSM states SHALL be IDLE, REFILL, RESPOND, FLUSH.
REQ-018 In IDLE with req sampled and a valid way's tag matching: cached_instr_valid SHALL pulse the next cycle with the hit word; no downstream traffic.
REQ-019 On miss, SHALL enter REFILL, read words 0..LINE_WORDS-1 of the line in ascending order at {tag,index,word,2'b00}.
REQ-020 Per word: instr_req high with instr_adr stable until instr_valid sampled; instr_req SHALL then drop for exactly one cycle before the next word.
REQ-021 Each instr_valid word SHALL be written into the victim way; tag and valid bit set with the last word.
REQ-022 After the last word, RESPOND SHALL pulse cached_instr_valid one cycle with the requested word, then IDLE.
REQ-023 Victim SHALL be the lowest-numbered invalid way; if none, the per-set round-robin pointer, which then increments modulo WAYS; WAYS=1 always way 0.
REQ-024 Flush in IDLE SHALL enter FLUSH, clearing one set's valid bits per cycle for 2^INDEX_BITS cycles, and reset all victim pointers to 0.
REQ-025 Flush during REFILL/RESPOND SHALL be latched, flush_busy set next cycle, executed after RESPOND completes.
REQ-026 Simultaneous flush and req in IDLE: flush SHALL win; request served after FLUSH, from an empty cache.
REQ-027 Requests SHALL not be accepted in FLUSH; flush_busy drops the cycle FLUSH exits.
REQ-028 cached_instr_read SHALL hold its last value when cached_instr_valid is low.

Reset
REQ-029 resn low SHALL immediately force: state IDLE, all valid bits 0, victim pointers 0, pending flush 0, cached_instr_valid 0, cached_instr_read 0, instr_req 0, instr_adr 0, flush_busy 0.
REQ-030 Reset mid-refill SHALL abandon the line (left invalid); tag/data arrays need not be reset.

Structure
REQ-031 Shared package icache_pkg SHALL hold the state enum and address-field width/extraction constants/functions.
REQ-032 Sub-module icache_way SHALL hold one way's tag, valid and data storage with lookup and write ports; instantiated WAYS times.

Verification (INDEX_BITS=6, WAYS=2, LINE_WORDS=4)
REQ-033 Cold req 0x0000_0104 -> downstream 0x100,0x104,0x108,0x10C, response = word at 0x104; then req 0x108 -> valid next cycle, instr_req stays 0.
REQ-034 Fill 0x100, 0x500, then 0x900 (all index 0x10) -> 0x900 evicts 0x100's way; 0x500 hits, 0x100 misses.
REQ-035 flush pulsed during second refill word -> refill and response complete, flush_busy high through 64 FLUSH cycles, then 0x104 misses.
REQ-036 resn low during third refill word -> all outputs 0 at once; after release 0x104 triggers full 4-word refill.
REQ-037 instr_valid delayed 5 cycles per word -> instr_adr stable and instr_req high throughout each wait, one low cycle between words.
REQ-038 flush and req 0x100 same IDLE cycle -> 64 FLUSH cycles first, then miss refill of 0x100.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: FSM state type and address-field helpers shared by the icache_assoc slice.
package icache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, RESPOND, FLUSH} state_e;
  localparam int ADR_W = 32;
  function automatic int tag_bits(input int index_bits, input int line_words);
    return ADR_W - 2 - index_bits - $clog2(line_words);
  endfunction
  function automatic logic [ADR_W-1:0] adr_word(input logic [ADR_W-1:0] adr, input int line_words);
    return (adr >> 2) & ADR_W'(line_words - 1);
  endfunction
  function automatic logic [ADR_W-1:0] adr_index(input logic [ADR_W-1:0] adr, input int index_bits,
                                                 input int line_words);
    return (adr >> (2 + $clog2(line_words))) & ((ADR_W'(1) << index_bits) - ADR_W'(1));
  endfunction
  function automatic logic [ADR_W-1:0] adr_tag(input logic [ADR_W-1:0] adr, input int index_bits,
                                               input int line_words);
    return adr >> (2 + $clog2(line_words) + index_bits);
  endfunction
endpackage

// File: rtl/icache_way.sv
// icache_way: one way's valid bits, tags and line data; combinational lookup,
// word write during refill, tag/valid fill on the last word and per-set invalidate.
module icache_way
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int LINE_WORDS = 4,
  parameter int WW         = 2,
  parameter int TAG_W      = 22
) (
  input  logic                  clk,
  input  logic                  resn,
  input  logic [INDEX_BITS-1:0] lk_index,
  input  logic [TAG_W-1:0]      lk_tag,
  input  logic [WW-1:0]         lk_word,
  output logic                  hit,
  output logic                  vld,
  output logic [ADR_W-1:0]      rd_data,
  input  logic                  wr_en,
  input  logic [WW-1:0]         wr_word,
  input  logic [ADR_W-1:0]      wr_data,
  input  logic                  fill_en,
  input  logic                  inv_en,
  input  logic [INDEX_BITS-1:0] inv_index
);
  localparam int SETS = 1 << INDEX_BITS;
  logic [SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [ADR_W-1:0] data_mem [SETS][LINE_WORDS];
  assign vld = valid_q[lk_index];
  assign hit = vld && tag_mem[lk_index] == lk_tag;
  assign rd_data = data_mem[lk_index][lk_word];
  always_comb begin
    valid_d = valid_q;
    if (inv_en) valid_d[inv_index] = 1'b0;
    if (fill_en) valid_d[lk_index] = 1'b1;
  end
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) valid_q <= '0;
    else valid_q <= valid_d;
  end
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[lk_index][wr_word] <= wr_data;
    if (fill_en) tag_mem[lk_index] <= lk_tag;
  end
endmodule

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with word-by-word line refill,
// round-robin replacement and a one-set-per-cycle flush sequencer.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        cached_instr_req,
  input  logic [31:0] cached_instr_adr,
  output logic        cached_instr_valid,
  output logic [31:0] cached_instr_read,
  output logic        instr_req,
  output logic [31:0] instr_adr,
  input  logic        instr_valid,
  input  logic [31:0] instr_read,
  input  logic        flush,
  output logic        flush_busy
);
  localparam int SETS  = 1 << INDEX_BITS;
  localparam int WW    = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
  localparam int VW    = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int TAG_W = tag_bits(INDEX_BITS, LINE_WORDS);
  state_e state_q, state_d;
  logic [31:0] adr_q, adr_d, cread_q, cread_d, iadr_q, iadr_d;
  logic [WW-1:0] word_q, word_d;
  logic [VW-1:0] victim_q, victim_d;
  logic [SETS-1:0][VW-1:0] rr_q, rr_d;
  logic [INDEX_BITS-1:0] fcnt_q, fcnt_d;
  logic pend_q, pend_d, cvalid_q, cvalid_d, ireq_q, ireq_d, busy_q, busy_d;
  logic [31:0] lk_adr, rdata;
  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_W-1:0] lk_tag;
  logic [WW-1:0] lk_word;
  logic [WAYS-1:0] hit_w, vld_w;
  logic [31:0] rd_w [WAYS];
  logic [VW-1:0] pick;
  logic wr_en, last;
  // Outside IDLE the lookup port follows the latched miss address, so RESPOND
  // reads the freshly filled word and refill writes land in the right set.
  assign lk_adr   = state_q == IDLE ? cached_instr_adr : adr_q;
  assign lk_index = INDEX_BITS'(adr_index(lk_adr, INDEX_BITS, LINE_WORDS));
  assign lk_tag   = TAG_W'(adr_tag(lk_adr, INDEX_BITS, LINE_WORDS));
  assign lk_word  = WW'(adr_word(lk_adr, LINE_WORDS));
  assign wr_en    = state_q == REFILL && ireq_q && instr_valid;
  assign last     = word_q == WW'(LINE_WORDS - 1);
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.INDEX_BITS(INDEX_BITS), .LINE_WORDS(LINE_WORDS), .WW(WW), .TAG_W(TAG_W)) u_way (
      .clk(clk), .resn(resn), .lk_index(lk_index), .lk_tag(lk_tag), .lk_word(lk_word),
      .hit(hit_w[w]), .vld(vld_w[w]), .rd_data(rd_w[w]),
      .wr_en(wr_en && victim_q == VW'(w)), .wr_word(word_q), .wr_data(instr_read),
      .fill_en(wr_en && last && victim_q == VW'(w)),
      .inv_en(state_q == FLUSH), .inv_index(fcnt_q)
    );
  end
  always_comb begin
    rdata = '0;
    pick = rr_q[lk_index];
    for (int i = WAYS - 1; i >= 0; i--) if (!vld_w[i]) pick = VW'(i);
    for (int i = 0; i < WAYS; i++)
      if (state_q == RESPOND ? victim_q == VW'(i) : hit_w[i]) rdata = rdata | rd_w[i];
  end
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    word_d = word_q;
    victim_d = victim_q;
    rr_d = rr_q;
    fcnt_d = fcnt_q;
    pend_d = pend_q;
    cvalid_d = 1'b0;
    cread_d = cread_q;
    ireq_d = ireq_q;
    iadr_d = iadr_q;
    busy_d = busy_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          busy_d = 1'b1;
          fcnt_d = '0;
          rr_d = '0;
        end else if (cached_instr_req && |hit_w) begin
          cvalid_d = 1'b1;
          cread_d = rdata;
        end else if (cached_instr_req) begin
          state_d = REFILL;
          adr_d = cached_instr_adr;
          word_d = '0;
          victim_d = pick;
          ireq_d = 1'b1;
          iadr_d = cached_instr_adr & ~(32'(LINE_WORDS * 4) - 32'd1);
          if (&vld_w) rr_d[lk_index] = VW'((int'(rr_q[lk_index]) + 1) % WAYS);
        end
      end
      REFILL: begin
        if (flush) begin
          pend_d = 1'b1;
          busy_d = 1'b1;
        end
        if (ireq_q && instr_valid) begin
          ireq_d = 1'b0;
          word_d = word_q + WW'(1);
          iadr_d = iadr_q + 32'd4;
          state_d = last ? RESPOND : REFILL;
        end else if (!ireq_q) ireq_d = 1'b1;
      end
      RESPOND: begin
        cvalid_d = 1'b1;
        cread_d = rdata;
        state_d = flush || pend_q ? FLUSH : IDLE;
        busy_d = flush || pend_q;
        pend_d = 1'b0;
        fcnt_d = '0;
        if (flush || pend_q) rr_d = '0;
      end
      FLUSH: begin
        fcnt_d = fcnt_q + INDEX_BITS'(1);
        state_d = fcnt_q == INDEX_BITS'(SETS - 1) ? IDLE : FLUSH;
        busy_d = fcnt_q != INDEX_BITS'(SETS - 1);
      end
    endcase
  end
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q <= IDLE;
      adr_q <= '0;
      word_q <= '0;
      victim_q <= '0;
      rr_q <= '0;
      fcnt_q <= '0;
      pend_q <= 1'b0;
      cvalid_q <= 1'b0;
      cread_q <= '0;
      ireq_q <= 1'b0;
      iadr_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      word_q <= word_d;
      victim_q <= victim_d;
      rr_q <= rr_d;
      fcnt_q <= fcnt_d;
      pend_q <= pend_d;
      cvalid_q <= cvalid_d;
      cread_q <= cread_d;
      ireq_q <= ireq_d;
      iadr_q <= iadr_d;
      busy_q <= busy_d;
    end
  end
  assign cached_instr_valid = cvalid_q;
  assign cached_instr_read  = cread_q;
  assign instr_req          = ireq_q;
  assign instr_adr          = iadr_q;
  assign flush_busy         = busy_q;
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed bench for icache_assoc (64 sets, 2 ways, 4-word lines)
// with a downstream memory model that logs every word request it serves.
module tb_icache_assoc;
  logic clk = 1'b0;
  logic resn = 1'b0;
  logic cached_instr_req = 1'b0;
  logic [31:0] cached_instr_adr = '0;
  logic cached_instr_valid;
  logic [31:0] cached_instr_read;
  logic instr_req;
  logic [31:0] instr_adr;
  logic instr_valid;
  logic [31:0] instr_read;
  logic flush = 1'b0;
  logic flush_busy;
  int checks = 0;
  int passed = 0;
  int delay = 0;
  logic [31:0] adr_log [256];
  int gap_log [256];
  int nlog = 0, stab_err = 0, drop_err = 0, req_seen = 0;

  icache_assoc dut (
    .clk(clk), .resn(resn),
    .cached_instr_req(cached_instr_req), .cached_instr_adr(cached_instr_adr),
    .cached_instr_valid(cached_instr_valid), .cached_instr_read(cached_instr_read),
    .instr_req(instr_req), .instr_adr(instr_adr),
    .instr_valid(instr_valid), .instr_read(instr_read),
    .flush(flush), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[31:16] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Downstream memory: answers each request after `delay` waiting cycles and
  // records address, preceding low-gap length and handshake violations.
  initial begin : responder
    logic active;
    logic [31:0] cur;
    int wcnt, low_run;
    active = 1'b0; cur = '0; wcnt = 0; low_run = 0;
    instr_valid = 1'b0;
    instr_read = '0;
    forever begin
      @(negedge clk);
      if (instr_valid) instr_valid = 1'b0;
      if (!resn) begin
        active = 1'b0;
        wcnt = 0;
        low_run = 0;
      end else if (!instr_req) begin
        low_run++;
        if (active) drop_err++;
      end else begin
        req_seen++;
        if (!active) begin
          if (nlog < 256) gap_log[nlog] = low_run;
          active = 1'b1;
          cur = instr_adr;
          wcnt = 0;
        end else if (instr_adr !== cur) stab_err++;
        low_run = 0;
        if (wcnt == delay) begin
          instr_valid = 1'b1;
          instr_read = mword(instr_adr);
          if (nlog < 256) adr_log[nlog] = instr_adr;
          nlog++;
          active = 1'b0;
        end else wcnt++;
      end
    end
  end

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task start_req(input logic [31:0] a);
    @(negedge clk);
    cached_instr_adr = a;
    cached_instr_req = 1'b1;
  endtask

  task wait_valid(input string tag, output logic [31:0] data, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cached_instr_valid && cyc < 2000);
    if (!cached_instr_valid) chk({tag, " timeout"}, 32'd0, 32'd1);
    data = cached_instr_read;
    cached_instr_req = 1'b0;
  endtask

  task fetch(input string tag, input logic [31:0] a, output logic [31:0] data, output int cyc);
    start_req(a);
    wait_valid(tag, data, cyc);
  endtask

  task automatic check_line(input string tag, input int base, input logic [31:0] line);
    chk({tag, " words"}, 32'(nlog - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s adr%0d", tag, k), adr_log[base + k], line + 32'(4 * k));
      if (k > 0) chk($sformatf("%s gap%0d", tag, k), 32'(gap_log[base + k]), 32'd1);
    end
  endtask

  task automatic count_busy(input string tag, input int exp);
    int n;
    n = 0;
    while (flush_busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin : stimulus
    logic [31:0] d;
    int cyc, base, seen, se, de, n;
    #12;
    chk("rst valid", 32'(cached_instr_valid), 32'd0);
    chk("rst read", cached_instr_read, 32'd0);
    chk("rst instr_req", 32'(instr_req), 32'd0);
    chk("rst instr_adr", instr_adr, 32'd0);
    chk("rst flush_busy", 32'(flush_busy), 32'd0);
    @(negedge clk);
    resn = 1'b1;
    // Cold miss, then a hit in the same line
    base = nlog;
    fetch("cold", 32'h104, d, cyc);
    check_line("cold", base, 32'h100);
    chk("cold data", d, mword(32'h104));
    seen = req_seen;
    fetch("hit108", 32'h108, d, cyc);
    chk("hit108 data", d, mword(32'h108));
    chk("hit108 latency", 32'(cyc), 32'd1);
    chk("hit108 no traffic", 32'(req_seen), 32'(seen));
    // Replacement within set 0x10
    base = nlog;
    fetch("fill500", 32'h500, d, cyc);
    check_line("fill500", base, 32'h500);
    base = nlog;
    fetch("fill900", 32'h900, d, cyc);
    check_line("fill900", base, 32'h900);
    chk("fill900 data", d, mword(32'h900));
    seen = req_seen;
    fetch("hit504", 32'h504, d, cyc);
    chk("hit504 data", d, mword(32'h504));
    chk("hit504 latency", 32'(cyc), 32'd1);
    chk("hit504 no traffic", 32'(req_seen), 32'(seen));
    base = nlog;
    fetch("miss100", 32'h100, d, cyc);
    check_line("miss100", base, 32'h100);
    chk("miss100 data", d, mword(32'h100));
    fetch("hit904", 32'h904, d, cyc);
    chk("hit904 latency", 32'(cyc), 32'd1);
    chk("hit904 data", d, mword(32'h904));
    // Flush arriving mid-refill is deferred until the response is delivered
    delay = 2;
    base = nlog;
    start_req(32'h2008);
    n = 0;
    while (!(nlog == base + 1 && instr_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("flushmid reach word1", 32'(n < 200), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushmid busy early", 32'(flush_busy), 32'd1);
    wait_valid("flushmid", d, cyc);
    chk("flushmid data", d, mword(32'h2008));
    check_line("flushmid", base, 32'h2000);
    count_busy("flushmid busy cycles", 64);
    delay = 0;
    base = nlog;
    fetch("postflush", 32'h104, d, cyc);
    check_line("postflush", base, 32'h100);
    chk("postflush data", d, mword(32'h104));
    // Reset during the third refill word
    delay = 3;
    base = nlog;
    start_req(32'h204);
    n = 0;
    while (!(nlog == base + 2 && instr_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid reach word2", 32'(n < 200), 32'd1);
    #2;
    resn = 1'b0;
    cached_instr_req = 1'b0;
    #1;
    chk("rstmid valid", 32'(cached_instr_valid), 32'd0);
    chk("rstmid read", cached_instr_read, 32'd0);
    chk("rstmid instr_req", 32'(instr_req), 32'd0);
    chk("rstmid instr_adr", instr_adr, 32'd0);
    chk("rstmid flush_busy", 32'(flush_busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resn = 1'b1;
    delay = 0;
    base = nlog;
    fetch("afterrst", 32'h104, d, cyc);
    check_line("afterrst", base, 32'h100);
    chk("afterrst data", d, mword(32'h104));
    // Slow downstream: five wait cycles per word
    delay = 5;
    se = stab_err;
    de = drop_err;
    base = nlog;
    fetch("slow", 32'h304, d, cyc);
    check_line("slow", base, 32'h300);
    chk("slow data", d, mword(32'h304));
    chk("slow adr stable", 32'(stab_err), 32'(se));
    chk("slow req held", 32'(drop_err), 32'(de));
    delay = 0;
    // Flush and request in the same IDLE cycle
    seen = req_seen;
    base = nlog;
    @(negedge clk);
    flush = 1'b1;
    cached_instr_adr = 32'h100;
    cached_instr_req = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushreq busy", 32'(flush_busy), 32'd1);
    chk("flushreq no instr_req", 32'(instr_req), 32'd0);
    count_busy("flushreq busy cycles", 64);
    chk("flushreq quiet during flush", 32'(req_seen), 32'(seen));
    wait_valid("flushreq", d, cyc);
    check_line("flushreq", base, 32'h100);
    chk("flushreq data", d, mword(32'h100));
    fetch("hit10c", 32'h10C, d, cyc);
    chk("hit10c latency", 32'(cyc), 32'd1);
    chk("hit10c data", d, mword(32'h10C));
    @(negedge clk);
    chk("read held", cached_instr_read, mword(32'h10C));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
